// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: imem load port, run control and redirect inputs, PC and instruction outputs.
// master = sequencer/testbench side, slave = instr_fetch_unit.
interface instr_fetch_unit_if #(
    parameter int XLEN = 32,
    parameter int AW   = 6
);
    logic            load_en;
    logic [AW-1:0]   load_addr;
    logic [31:0]     load_data;
    logic            start;
    logic            stall;
    logic            pc_src;
    logic [XLEN-1:0] pc_target;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [31:0]     instr;
    logic [6:0]      op;
    logic            instr_valid;
    logic            halted;
    logic            fault;

    modport master (
        output load_en, load_addr, load_data, start, stall, pc_src, pc_target,
        input  pc, pc_plus4, instr, op, instr_valid, halted, fault
    );

    modport slave (
        input  load_en, load_addr, load_data, start, stall, pc_src, pc_target,
        output pc, pc_plus4, instr, op, instr_valid, halted, fault
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, word-addressed instruction memory with zero-latency read,
// and a load/run/halt/fault sequencer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | program loading allowed; waiting for start
// S_RUN   | fetching imem[pc] every cycle, PC advances/redirects
// S_HALT  | EBREAK retired; sticky until reset
// S_FAULT | misaligned redirect or out-of-range fetch; sticky until reset
module instr_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter int              IMEM_DEPTH = 64,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    instr_fetch_unit_if.slave bus
);
    localparam int              AW         = $clog2(IMEM_DEPTH);
    localparam logic [31:0]     NOP        = 32'h0000_0013;
    localparam logic [31:0]     EBREAK     = 32'h0010_0073;
    localparam logic [XLEN-1:0] IMEM_BYTES = XLEN'(4 * IMEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT,
        S_FAULT
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     imem_q [IMEM_DEPTH];
    logic [31:0]     fetch_word;
    logic            in_range;
    logic            running;
    logic            imem_we;

    assign running    = (state_q == S_RUN);
    assign in_range   = (pc_q < IMEM_BYTES);
    assign fetch_word = imem_q[pc_q[2 +: AW]];
    assign imem_we    = (state_q == S_IDLE) && bus.load_en;

    // Memory contents survive reset so a program can be restarted without reloading.
    always_ff @(posedge clk_i) begin
        if (imem_we) begin
            imem_q[bus.load_addr] <= bus.load_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    pc_d    = RESET_PC;
                end
            end
            S_RUN: begin
                // Out-of-range fetch faults even under stall and before EBREAK decode.
                if (!in_range) begin
                    state_d = S_FAULT;
                end else if (bus.stall) begin
                    pc_d = pc_q;
                end else if (fetch_word == EBREAK) begin
                    state_d = S_HALT;
                end else if (bus.pc_src && (bus.pc_target[1:0] != 2'b00)) begin
                    state_d = S_FAULT;
                end else if (bus.pc_src) begin
                    pc_d = bus.pc_target;
                end else begin
                    pc_d = pc_q + XLEN'(4);
                end
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.pc          = pc_q;
        bus.pc_plus4    = pc_q + XLEN'(4);
        bus.instr       = NOP;
        bus.instr_valid = 1'b0;
        bus.halted      = (state_q == S_HALT);
        bus.fault       = (state_q == S_FAULT);
        if (running && in_range) begin
            bus.instr       = fetch_word;
            bus.instr_valid = 1'b1;
        end
        bus.op = bus.instr[6:0];
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed vector bench for instr_fetch_unit: a table of {inputs, expected outputs} checked before
// each clock edge, plus a hand-written halt-stickiness sequence.
module tb_instr_fetch_unit;
    localparam logic [31:0] N  = 32'h0000_0013;
    localparam logic [31:0] EB = 32'h0010_0073;

    typedef struct {
        logic        rst_n;
        logic        load_en;
        logic [5:0]  load_addr;
        logic [31:0] load_data;
        logic        start;
        logic        stall;
        logic        pc_src;
        logic [31:0] pc_target;
        logic        chk;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_halt;
        logic        e_fault;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    vec_t vecs[$];

    instr_fetch_unit_if #(.XLEN(32), .AW(6)) ifc ();

    instr_fetch_unit #(
        .XLEN      (32),
        .IMEM_DEPTH(64),
        .RESET_PC  (32'h0)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] fw(input int i);
        return 32'h0000_0033 | (32'(i) << 7);
    endfunction

    function automatic vec_t mk(input int r, input int le, input int la, input logic [31:0] ld,
                                input int st, input int sl, input int ps, input logic [31:0] pt,
                                input int ck, input logic [31:0] epc, input logic [31:0] ein,
                                input int ev, input int eh, input int ef);
        vec_t v;
        v.rst_n     = (r != 0);
        v.load_en   = (le != 0);
        v.load_addr = 6'(la);
        v.load_data = ld;
        v.start     = (st != 0);
        v.stall     = (sl != 0);
        v.pc_src    = (ps != 0);
        v.pc_target = pt;
        v.chk       = (ck != 0);
        v.e_pc      = epc;
        v.e_instr   = ein;
        v.e_valid   = (ev != 0);
        v.e_halt    = (eh != 0);
        v.e_fault   = (ef != 0);
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        ifc.load_en   = 1'b0;
        ifc.load_addr = '0;
        ifc.load_data = '0;
        ifc.start     = 1'b0;
        ifc.stall     = 1'b0;
        ifc.pc_src    = 1'b0;
        ifc.pc_target = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input int idx, input logic [31:0] epc, input logic [31:0] ein,
                                 input logic ev, input logic eh, input logic ef);
        logic [31:0] e_p4;
        logic [31:0] e_op;
        e_p4 = epc + 32'd4;
        e_op = {25'd0, ein[6:0]};
        chk("pc",          idx, ifc.pc,                 epc);
        chk("pc_plus4",    idx, ifc.pc_plus4,           e_p4);
        chk("instr",       idx, ifc.instr,              ein);
        chk("op",          idx, {25'd0, ifc.op},        e_op);
        chk("instr_valid", idx, {31'd0, ifc.instr_valid}, {31'd0, ev});
        chk("halted",      idx, {31'd0, ifc.halted},    {31'd0, eh});
        chk("fault",       idx, {31'd0, ifc.fault},     {31'd0, ef});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        drive_idle();
        tick();
        tick();

        // Fill every word with a known non-EBREAK pattern so any fetch is defined.
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            ifc.load_en   = 1'b1;
            ifc.load_addr = 6'(i);
            ifc.load_data = fw(i);
            tick();
        end
        drive_idle();

        //             r le la ld            st sl ps pt            ck pc            instr       v  h  f
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        N,          0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        N,          0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h33,       0, 0, 0, 32'h0,        1, 32'h0,        N,          0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 32'h03,       0, 0, 0, 32'h0,        1, 32'h0,        N,          0, 0, 0));
        vecs.push_back(mk(1, 1, 2, 32'h63,       1, 0, 0, 32'h0,        1, 32'h0,        N,          0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        32'h33,     1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h4,        32'h03,     1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1, 32'h4,        1, 32'h8,        32'h63,     1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 1, 32'h20,       1, 32'h4,        32'h03,     1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1, 32'h20,       1, 32'h4,        32'h03,     1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1, 32'h4,        1, 32'h20,       fw(8),      1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1, 32'h22,       1, 32'h4,        32'h03,     1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h4,        N,          0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 32'hDEADBEEF, 1, 0, 0, 32'h0,        1, 32'h4,        N,          0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h4,        N,          0, 0, 1));
        vecs.push_back(mk(1, 1, 3, EB,           1, 0, 0, 32'h0,        1, 32'h0,        N,          0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        32'h33,     1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h4,        32'h03,     1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h8,        32'h63,     1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'hC,        EB,         1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1, 32'h20,       1, 32'hC,        EB,         1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0, 0, 32'h0,        1, 32'hC,        N,          0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'hC,        N,          0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0, 0, 32'h0,        1, 32'h0,        N,          0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1, 32'hF8,       1, 32'h0,        32'h33,     1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'hF8,       fw(62),     1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'hFC,       fw(63),     1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h100,      N,          0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h100,      N,          0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h100,      N,          0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0, 0, 32'h0,        1, 32'h0,        N,          0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        32'h33,     1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h4,        32'h03,     1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h8,        32'h63,     1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0, 0, 32'h0,        1, 32'h0,        N,          0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1, 32'hFFFFFFFC, 1, 32'h0,        32'h33,     1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'hFFFFFFFC, N,          0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'hFFFFFFFC, N,          0, 0, 1));

        foreach (vecs[i]) begin
            rst_n         = vecs[i].rst_n;
            ifc.load_en   = vecs[i].load_en;
            ifc.load_addr = vecs[i].load_addr;
            ifc.load_data = vecs[i].load_data;
            ifc.start     = vecs[i].start;
            ifc.stall     = vecs[i].stall;
            ifc.pc_src    = vecs[i].pc_src;
            ifc.pc_target = vecs[i].pc_target;
            #1;
            if (vecs[i].chk) begin
                check_outputs(i, vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_valid,
                              vecs[i].e_halt, vecs[i].e_fault);
            end
            @(posedge clk);
            #1;
        end

        // Redirect onto the EBREAK at 0xC, wait bounded for halt, then confirm HALT ignores everything.
        drive_idle();
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        ifc.start = 1'b1;
        tick();
        ifc.start     = 1'b0;
        ifc.pc_src    = 1'b1;
        ifc.pc_target = 32'hC;
        tick();
        drive_idle();
        begin
            int waited;
            waited = 0;
            while (!ifc.halted && waited < 10) begin
                tick();
                waited++;
            end
            chk("halt_reached", 100, {31'd0, ifc.halted}, 32'd1);
        end
        for (int k = 0; k < 5; k++) begin
            ifc.start     = 1'b1;
            ifc.load_en   = 1'b1;
            ifc.load_addr = 6'd3;
            ifc.load_data = 32'h0000_0033;
            ifc.pc_src    = 1'b1;
            ifc.pc_target = 32'h40;
            tick();
            chk("halt_sticky", 101 + k, {31'd0, ifc.halted}, 32'd1);
            chk("halt_pc",     101 + k, ifc.pc, 32'hC);
            chk("halt_valid",  101 + k, {31'd0, ifc.instr_valid}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
